uart_loader: RTL and testbench

Boot loader that drives the UART peripheral's memory-mapped port as a bus initiator. After reset it holds the CPU in reset and drains the UART receive ring: first a 4-byte word count, then that many 32-bit little-endian words. Each complete word is written into instruction memory starting at word 0, after which the CPU is released. It sits between the UART peripheral, the instruction RAM write port and the core's reset input, and replaces the UART's CPU-side master only while booting.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_byte_reader.sv | 45 ++++
 rtl/uart_loader.sv | 199 +++++++++++++++++++
 tb/tb_uart_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART register map, field positions and boot-loader state encoding.
package uart_pkg;

  localparam logic [5:0] UART_REG_CTRL = 6'h00;
  localparam logic [5:0] UART_RXBUF    = 6'h10;
  localparam logic [5:0] UART_TXBUF    = 6'h20;

  localparam int RX_PTR_LSB  = 8;
  localparam int TX_HEAD_LSB = 4;
  localparam int TX_PTR_LSB  = 0;

  typedef enum logic [2:0] {
    ST_SYNC     = 3'd0,
    ST_POLL     = 3'd1,
    ST_FETCH    = 3'd2,
    ST_WORD     = 3'd3,
    ST_DONE     = 3'd4,
    ST_ACK_WAIT = 3'd5,
    ST_ACK_DATA = 3'd6,
    ST_ACK_PTR  = 3'd7
  } ld_state_e;

  // Ring byte i lives in word {2'b01, i[3:2], 2'b00}, lane i[1:0].
  function automatic logic [5:0] rx_word_addr(input logic [3:0] ptr);
    return UART_RXBUF | {2'b00, ptr[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/uart_byte_reader.sv
// Receive-ring cursor: tracks the loader's read pointer and extracts the next byte.
module uart_byte_reader
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sync_i,
  input  logic        fetch_i,
  input  logic [31:0] uart_rdata_i,
  output logic [5:0]  ring_addr_o,
  output logic        avail_o,
  output logic [7:0]  byte_o
);

  logic [3:0] rd_ptr_q;
  logic [3:0] rd_ptr_d;
  logic [3:0] rx_ptr_s;

  assign rx_ptr_s = uart_rdata_i[RX_PTR_LSB +: 4];

  // SYNC adopts the UART's write pointer so stale ring contents are skipped.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (sync_i) begin
      rd_ptr_d = rx_ptr_s;
    end else if (fetch_i) begin
      rd_ptr_d = rd_ptr_q + 4'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 4'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign ring_addr_o = rx_word_addr(rd_ptr_q);
  assign avail_o     = (rx_ptr_s != rd_ptr_q);
  assign byte_o      = uart_rdata_i[{rd_ptr_q[1:0], 3'b000} +: 8];

endmodule

// File: rtl/uart_loader.sv
// Boot loader: drains a word-count header plus little-endian words from the UART into instruction RAM.
// Optional checksum acknowledge over the TX ring is enabled by defining UART_LOADER_ACK_EN.
module uart_loader
  import uart_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic [5:0]        uart_addr,
  input  logic [31:0]       uart_rdata,
  output logic [31:0]       uart_wdata,
  output logic              uart_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              cpu_rst,
  output logic              done
);

  ld_state_e         state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       words_left_q, words_left_d;
  logic              hdr_q, hdr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              full_q, full_d;
`ifdef UART_LOADER_ACK_EN
  logic [7:0]        sum_q, sum_d;
  logic [3:0]        tx_ptr_q, tx_ptr_d;
`endif

  logic [5:0] ring_addr_s;
  logic       avail_s;
  logic [7:0] byte_s;

  uart_byte_reader u_reader (
    .clk          (clk),
    .rst          (rst),
    .sync_i       (state_q == ST_SYNC),
    .fetch_i      (state_q == ST_FETCH),
    .uart_rdata_i (uart_rdata),
    .ring_addr_o  (ring_addr_s),
    .avail_o      (avail_s),
    .byte_o       (byte_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; after the final payload word the ACK build detours via the TX handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:  state_d = ST_POLL;
      ST_POLL:  state_d = avail_s ? ST_FETCH : ST_POLL;
      ST_FETCH: state_d = (byte_cnt_q == 2'd3) ? ST_WORD : ST_POLL;
      ST_WORD: begin
        if (hdr_q) begin
          state_d = (shift_q == 32'd0) ? ST_DONE : ST_POLL;
        end else if (words_left_q == 32'd1) begin
`ifdef UART_LOADER_ACK_EN
          state_d = ST_ACK_WAIT;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_POLL;
        end
      end
      ST_DONE:  state_d = ST_DONE;
`ifdef UART_LOADER_ACK_EN
      ST_ACK_WAIT: begin
        if (uart_rdata[TX_HEAD_LSB +: 4] == uart_rdata[TX_PTR_LSB +: 4]) begin
          state_d = ST_ACK_DATA;
        end else begin
          state_d = ST_ACK_WAIT;
        end
      end
      ST_ACK_DATA: state_d = ST_ACK_PTR;
      ST_ACK_PTR:  state_d = ST_DONE;
`endif
      default:  state_d = ST_SYNC;
    endcase
  end

  // Byte assembly, word bookkeeping and write-address advance.
  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    words_left_d = words_left_q;
    hdr_d        = hdr_q;
    mem_addr_d   = mem_addr_q;
    full_d       = full_q;
`ifdef UART_LOADER_ACK_EN
    sum_d        = sum_q;
    tx_ptr_d     = tx_ptr_q;
`endif
    case (state_q)
      ST_SYNC: begin
        hdr_d      = 1'b1;
        byte_cnt_d = 2'd0;
      end
      ST_FETCH: begin
        shift_d[{byte_cnt_q, 3'b000} +: 8] = byte_s;
        byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef UART_LOADER_ACK_EN
        if (!hdr_q) begin
          sum_d = sum_q + byte_s;
        end else begin
          sum_d = sum_q;
        end
`endif
      end
      ST_WORD: begin
        if (hdr_q) begin
          words_left_d = shift_q;
          hdr_d        = 1'b0;
        end else begin
          words_left_d = words_left_q - 32'd1;
          // Once the address wraps the RAM is full; later words are only consumed.
          if (!full_q) begin
            mem_addr_d = mem_addr_q + 1'b1;
            full_d     = (mem_addr_q == {ADDR_W{1'b1}});
          end else begin
            mem_addr_d = mem_addr_q;
          end
        end
      end
`ifdef UART_LOADER_ACK_EN
      ST_ACK_WAIT: tx_ptr_d = uart_rdata[TX_PTR_LSB +: 4];
`endif
      default: begin
        hdr_d = hdr_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q   <= 2'd0;
      shift_q      <= 32'd0;
      words_left_q <= 32'd0;
      hdr_q        <= 1'b1;
      mem_addr_q   <= {ADDR_W{1'b0}};
      full_q       <= 1'b0;
`ifdef UART_LOADER_ACK_EN
      sum_q        <= 8'd0;
      tx_ptr_q     <= 4'd0;
`endif
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      words_left_q <= words_left_d;
      hdr_q        <= hdr_d;
      mem_addr_q   <= mem_addr_d;
      full_q       <= full_d;
`ifdef UART_LOADER_ACK_EN
      sum_q        <= sum_d;
      tx_ptr_q     <= tx_ptr_d;
`endif
    end
  end

  // Bus outputs decoded from state; the UART read path stays combinational.
  always_comb begin
    uart_addr  = UART_REG_CTRL;
    uart_wdata = 32'd0;
    uart_we    = 1'b0;
    case (state_q)
      ST_FETCH: uart_addr = ring_addr_s;
`ifdef UART_LOADER_ACK_EN
      ST_ACK_DATA: begin
        uart_addr  = UART_TXBUF | {2'b00, tx_ptr_q[3:2], 2'b00};
        uart_wdata = {4{sum_q}};
        uart_we    = 1'b1;
      end
      ST_ACK_PTR: begin
        uart_addr  = UART_REG_CTRL;
        uart_wdata = {28'd0, tx_ptr_q + 4'd1};
        uart_we    = 1'b1;
      end
`endif
      default: uart_addr = UART_REG_CTRL;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = shift_q;
  assign mem_we    = (state_q == ST_WORD) && !hdr_q && !full_q;
  assign done      = (state_q == ST_DONE);
  assign cpu_rst   = (state_q != ST_DONE);

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: a behavioural UART ring feeds two loaders (ADDR_W=10 and ADDR_W=2).
module tb_uart_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [5:0]  ua_addr, ub_addr;
  logic [31:0] ua_rdata, ub_rdata, ua_wdata, ub_wdata;
  logic        ua_we, ub_we;
  logic [9:0]  ma_addr;
  logic [1:0]  mb_addr;
  logic [31:0] ma_wdata, mb_wdata;
  logic        ma_we, mb_we, cpu_rst_a, cpu_rst_b, done_a, done_b;

  uart_loader #(.ADDR_W(10)) dut_a (
    .clk(clk), .rst(rst), .uart_addr(ua_addr), .uart_rdata(ua_rdata), .uart_wdata(ua_wdata),
    .uart_we(ua_we), .mem_addr(ma_addr), .mem_wdata(ma_wdata), .mem_we(ma_we),
    .cpu_rst(cpu_rst_a), .done(done_a));

  uart_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .uart_addr(ub_addr), .uart_rdata(ub_rdata), .uart_wdata(ub_wdata),
    .uart_we(ub_we), .mem_addr(mb_addr), .mem_wdata(mb_wdata), .mem_we(mb_we),
    .cpu_rst(cpu_rst_b), .done(done_b));

  // UART model: shared RX ring; TX side belongs to dut_a only
  logic [7:0]  ring [16];
  logic [3:0]  rx_ptr = 4'd0;
  logic [3:0]  tx_ptr = 4'd5;
  logic [3:0]  tx_head = 4'd3;
  logic [31:0] txring [4];
  logic [7:0]  tx_line = 8'd0;

  always_comb begin
    ua_rdata = 32'd0;
    if (ua_addr == 6'h00)
      ua_rdata = {20'd0, rx_ptr, tx_head, tx_ptr};
    else if (ua_addr[5:4] == 2'b01)
      ua_rdata = {ring[{ua_addr[3:2], 2'd3}], ring[{ua_addr[3:2], 2'd2}],
                  ring[{ua_addr[3:2], 2'd1}], ring[{ua_addr[3:2], 2'd0}]};
    else if (ua_addr[5:4] == 2'b10)
      ua_rdata = txring[ua_addr[3:2]];
  end

  always_comb begin
    ub_rdata = 32'd0;
    if (ub_addr == 6'h00)
      ub_rdata = {20'd0, rx_ptr, 8'd0};
    else if (ub_addr[5:4] == 2'b01)
      ub_rdata = {ring[{ub_addr[3:2], 2'd3}], ring[{ub_addr[3:2], 2'd2}],
                  ring[{ub_addr[3:2], 2'd1}], ring[{ub_addr[3:2], 2'd0}]};
  end

  // Observers: memory write logs, fetch/done timing, UART write activity
  logic [9:0]  wa_addr [$];
  logic [31:0] wa_data [$];
  logic [1:0]  wb_addr [$];
  logic [31:0] wb_data [$];
  int   cyc = 0;
  int   last_fetch_a = 0;
  int   done_cyc_a = 0;
  logic done_seen_a = 1'b0;
  logic we_seen = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      wa_addr.delete(); wa_data.delete(); wb_addr.delete(); wb_data.delete();
      done_seen_a <= 1'b0;
      we_seen <= 1'b0;
    end else begin
      if (ma_we) begin wa_addr.push_back(ma_addr); wa_data.push_back(ma_wdata); end
      if (mb_we) begin wb_addr.push_back(mb_addr); wb_data.push_back(mb_wdata); end
      if (ua_addr[5:4] == 2'b01) last_fetch_a <= cyc;
      if (done_a && !done_seen_a) begin done_seen_a <= 1'b1; done_cyc_a <= cyc; end
      if (ua_we || ub_we) we_seen <= 1'b1;
    end
    if (ua_we) begin
      if (ua_addr == 6'h00) tx_ptr <= ua_wdata[3:0];
      else if (ua_addr[5:4] == 2'b10) txring[ua_addr[3:2]] <= ua_wdata;
    end
    if (tx_head != tx_ptr) begin
      tx_line <= txring[tx_head[3:2]][{tx_head[1:0], 3'b000} +: 8];
      tx_head <= tx_head + 4'd1;
    end
  end

  int tests = 0;
  int fails = 0;
  logic [7:0] img [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    ring[rx_ptr] = b;
    rx_ptr = rx_ptr + 4'd1;
    repeat ($urandom_range(2, 6)) @(negedge clk);
  endtask

  task automatic do_reset(input bit set_ptr, input logic [3:0] p);
    @(negedge clk);
    rst = 1'b1;
    if (set_ptr) rx_ptr = p;
    repeat (2) @(negedge clk);
    chk("rst_uart_addr", {ub_addr, 10'd0, ua_addr}, 32'd0);
    chk("rst_uart_we", {ub_we, ua_we}, 32'd0);
    chk("rst_uart_wdata", ua_wdata | ub_wdata, 32'd0);
    chk("rst_mem", {ma_we, mb_we, mb_addr, ma_addr}, 32'd0);
    chk("rst_mem_wdata", ma_wdata | mb_wdata, 32'd0);
    chk("rst_cpu_done", {cpu_rst_a, cpu_rst_b, done_a, done_b}, 32'hC);
    rst = 1'b0;
  endtask

  task automatic build_random(input int n);
    img.delete();
    for (int k = 0; k < 4; k++) img.push_back(8'((n >> (8 * k)) & 255));
    for (int k = 0; k < 4 * n; k++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  function automatic logic [31:0] le_word(input int base);
    return {img[base + 3], img[base + 2], img[base + 1], img[base]};
  endfunction

  task automatic run_image(input string tag);
    int n, nb, budget;
    logic [7:0] sum;
    logic [3:0] old_tx;
    n = int'(le_word(0));
    nb = (n < 4) ? n : 4;
    sum = 8'd0;
    for (int k = 4; k < img.size(); k++) sum = sum + img[k];
    old_tx = tx_ptr;
    foreach (img[k]) push_byte(img[k]);
    budget = 0;
    while (!(done_a && done_b) && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    chk({tag, "_done_in_time"}, {31'd0, budget < 400}, 32'd1);
    repeat (4) @(negedge clk);
    chk({tag, "_done_cpu"}, {cpu_rst_a, cpu_rst_b, done_a, done_b}, 32'h3);
    chk({tag, "_nwr_a"}, wa_data.size(), n);
    chk({tag, "_nwr_b"}, wb_data.size(), nb);
    for (int i = 0; i < n && i < wa_data.size(); i++) begin
      chk($sformatf("%s_a_addr%0d", tag, i), {22'd0, wa_addr[i]}, i);
      chk($sformatf("%s_a_data%0d", tag, i), wa_data[i], le_word(4 + 4 * i));
    end
    for (int i = 0; i < nb && i < wb_data.size(); i++) begin
      chk($sformatf("%s_b_addr%0d", tag, i), {30'd0, wb_addr[i]}, i);
      chk($sformatf("%s_b_data%0d", tag, i), wb_data[i], le_word(4 + 4 * i));
    end
`ifdef UART_LOADER_ACK_EN
    if (n > 0) begin
      chk({tag, "_ack_word"}, txring[old_tx[3:2]], {4{sum}});
      chk({tag, "_ack_ptr"}, {28'd0, tx_ptr}, {28'd0, old_tx + 4'd1});
      chk({tag, "_ack_line"}, {24'd0, tx_line}, {24'd0, sum});
    end
`else
    chk({tag, "_no_uart_we"}, {31'd0, we_seen}, 32'd0);
`endif
  endtask

  initial begin
    for (int k = 0; k < 16; k++) ring[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 4; k++) txring[k] = 32'd0;
    rst = 1'b1;

    do_reset(1'b1, 4'd0);
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_image("img1");
    chk("img1_word0", wa_data.size() > 0 ? wa_data[0] : 32'd0, 32'h12345678);
    chk("img1_word1", wa_data.size() > 1 ? wa_data[1] : 32'd0, 32'hDEADBEEF);
`ifdef UART_LOADER_ACK_EN
    chk("img1_ack_const", txring[1], 32'h4C4C4C4C);
`endif

    do_reset(1'b0, 4'd0);
    img = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_image("hdr0");
    chk("hdr0_done_latency", done_cyc_a - last_fetch_a, 32'd2);

    // stale bytes arrive while the loader is idle in DONE, then a reset pulse
    for (int k = 0; k < 3; k++) push_byte(8'($urandom_range(0, 255)));
    do_reset(1'b0, 4'd0);
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_image("stale");

    do_reset(1'b1, 4'd14);
    build_random(4);
    run_image("wrap");

    do_reset(1'b1, 4'($urandom_range(0, 15)));
    build_random(6);
    run_image("cap");

    for (int r = 0; r < 4; r++) begin
      do_reset(1'b1, 4'($urandom_range(0, 15)));
      build_random($urandom_range(0, 7));
      run_image($sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
